// File: rtl/alu_pkg.sv
// Shared types and op encodings for the ALU logic path and its requester arbiter.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package alu_pkg;

  localparam int DATA_W = 16;

  // Logic-unit op codes; 5..7 are unassigned and treated as illegal.
  localparam logic [2:0] LOGIC_AND  = 3'd0;
  localparam logic [2:0] LOGIC_OR   = 3'd1;
  localparam logic [2:0] LOGIC_XOR  = 3'd2;
  localparam logic [2:0] LOGIC_NOT  = 3'd3;
  localparam logic [2:0] LOGIC_TEST = 3'd4;

  typedef enum logic [0:0] {
    LA_ARB    = 1'b0,
    LA_LOCKED = 1'b1
  } logic_arb_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              zero;
    logic              neg;
    logic              parity;
    logic              wb;
    logic              illegal;
  } logic_rsp_t;

  function automatic logic is_legal_logic_ctrl(input logic [2:0] ctrl);
    logic legal;
    legal = 1'b0;
    case (ctrl)
      LOGIC_AND, LOGIC_OR, LOGIC_XOR, LOGIC_NOT, LOGIC_TEST: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

  // Flags are always derived from the unit's result; TEST and illegal ops never write back.
  function automatic logic_rsp_t make_logic_rsp(input logic [DATA_W-1:0] result,
                                                input logic [2:0]        ctrl);
    logic_rsp_t rsp;
    rsp.result  = result;
    rsp.zero    = (result == '0);
    rsp.neg     = result[DATA_W-1];
    rsp.parity  = ^result;
    rsp.wb      = is_legal_logic_ctrl(ctrl) && (ctrl != LOGIC_TEST);
    rsp.illegal = !is_legal_logic_ctrl(ctrl);
    return rsp;
  endfunction

endpackage

// File: rtl/alu_logic_unit.sv
// Bitwise logic datapath: AND/OR/XOR/NOT/TEST on two 16-bit operands.
// Latency: 0 (purely combinational).
// Backpressure: none; the caller registers the result.
module alu_logic_unit
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [2:0]        i_ctrl,
  output logic [DATA_W-1:0] o_result
);

  // Op decode; TEST shares the AND datapath, unknown codes yield zero.
  always_comb begin
    o_result = '0;
    case (i_ctrl)
      LOGIC_AND:  o_result = i_a & i_b;
      LOGIC_OR:   o_result = i_a | i_b;
      LOGIC_XOR:  o_result = i_a ^ i_b;
      LOGIC_NOT:  o_result = ~i_a;
      LOGIC_TEST: o_result = i_a & i_b;
      default:    o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin pick: first eligible request at or after i_ptr, wrapping to 0.
// Latency: 0 (combinational); pointer state lives in the caller.
// Backpressure: none; the caller qualifies the grant with its own accept condition.
module alu_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDW-1:0]     i_ptr,
  input  logic [NUM_REQ-1:0] i_mask,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDW-1:0]     o_grant_id
);

  logic [NUM_REQ-1:0] w_eligible;

  assign w_eligible = i_req & i_mask;

  // Scan NUM_REQ slots starting at the pointer; one extra index bit absorbs the wrap.
  always_comb begin
    logic         found;
    logic [IDW:0] idx;
    o_grant    = '0;
    o_grant_id = '0;
    found      = 1'b0;
    idx        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, i_ptr} + (IDW+1)'(i);
      if (idx >= (IDW+1)'(NUM_REQ)) begin
        idx = idx - (IDW+1)'(NUM_REQ);
      end
      if (!found && w_eligible[idx[IDW-1:0]]) begin
        found                   = 1'b1;
        o_grant[idx[IDW-1:0]]   = 1'b1;
        o_grant_id              = idx[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/alu_logic_arbiter.sv
// Shares one alu_logic_unit among NUM_REQ requesters with round-robin grant and optional locked sequences.
// Latency: 1 cycle from accept to o_rsp_valid; 1 op/cycle with o_rsp_ready held high.
// Backpressure: response register holds while stalled; requests accepted only when it is empty or draining.
module alu_logic_arbiter
  import alu_pkg::*;
#(
  parameter  int NUM_REQ  = 4,
  parameter  int LOCK_MAX = 8,
  localparam int IDW      = $clog2(NUM_REQ)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  output logic [NUM_REQ-1:0]        o_req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_a,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_b,
  input  logic [NUM_REQ*3-1:0]      i_req_ctrl,
  input  logic [NUM_REQ-1:0]        i_req_lock,
  output logic                      o_rsp_valid,
  input  logic                      i_rsp_ready,
  output logic [IDW-1:0]            o_rsp_id,
  output logic [DATA_W-1:0]         o_rsp_result,
  output logic                      o_rsp_zero,
  output logic                      o_rsp_neg,
  output logic                      o_rsp_parity,
  output logic                      o_rsp_wb,
  output logic                      o_rsp_illegal,
  output logic                      o_lock_timeout
);

  localparam int CNTW = $clog2(LOCK_MAX + 1);

  logic_arb_state_e r_state;
  logic_arb_state_e w_state_nxt;
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   r_owner;
  logic [CNTW-1:0]  r_lock_cnt;
  logic             r_rsp_valid;
  logic [IDW-1:0]   r_rsp_id;
  logic_rsp_t       r_rsp;

  logic [NUM_REQ-1:0] w_mask;
  logic [NUM_REQ-1:0] w_grant;
  logic [IDW-1:0]     w_grant_id;
  logic [NUM_REQ-1:0] w_req_ready;
  logic               w_can_accept;
  logic               w_accept;
  logic               w_timeout;
  logic [DATA_W-1:0]  w_sel_a;
  logic [DATA_W-1:0]  w_sel_b;
  logic [2:0]         w_sel_ctrl;
  logic               w_sel_lock;
  logic [DATA_W-1:0]  w_result;
  logic_rsp_t         w_rsp;
  logic [IDW-1:0]     w_grant_ptr_nxt;
  logic [IDW-1:0]     w_owner_ptr_nxt;

  // The register can take a new op when empty or when its current contents drain this cycle.
  assign w_can_accept = !r_rsp_valid || i_rsp_ready;
  assign w_timeout    = (r_state == LA_LOCKED) && (r_lock_cnt == CNTW'(LOCK_MAX));
  assign w_req_ready  = w_grant & {NUM_REQ{w_can_accept && !i_rst}};
  assign w_accept     = |w_req_ready;
  assign o_req_ready  = w_req_ready;

  assign w_grant_ptr_nxt = (w_grant_id == IDW'(NUM_REQ - 1)) ? '0 : w_grant_id + IDW'(1);
  assign w_owner_ptr_nxt = (r_owner    == IDW'(NUM_REQ - 1)) ? '0 : r_owner    + IDW'(1);

  alu_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .i_req      (i_req_valid),
    .i_ptr      (r_ptr),
    .i_mask     (w_mask),
    .o_grant    (w_grant),
    .o_grant_id (w_grant_id)
  );

  // Steer the granted requester's operands into the shared logic unit.
  always_comb begin
    w_sel_a    = '0;
    w_sel_b    = '0;
    w_sel_ctrl = '0;
    w_sel_lock = 1'b0;
    for (int g = 0; g < NUM_REQ; g++) begin
      if (w_grant[g]) begin
        w_sel_a    = i_req_a[g*DATA_W +: DATA_W];
        w_sel_b    = i_req_b[g*DATA_W +: DATA_W];
        w_sel_ctrl = i_req_ctrl[g*3 +: 3];
        w_sel_lock = i_req_lock[g];
      end
    end
  end

  alu_logic_unit u_logic_unit (
    .i_a      (w_sel_a),
    .i_b      (w_sel_b),
    .i_ctrl   (w_sel_ctrl),
    .o_result (w_result)
  );

  assign w_rsp = make_logic_rsp(w_result, w_sel_ctrl);

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= LA_ARB;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: lock on a locked accept, release on an unlocked owner accept or timeout.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      LA_ARB: begin
        if (w_accept && w_sel_lock) begin
          w_state_nxt = LA_LOCKED;
        end
      end
      LA_LOCKED: begin
        if (w_timeout || (w_accept && !w_sel_lock)) begin
          w_state_nxt = LA_ARB;
        end
      end
      default: w_state_nxt = LA_ARB;
    endcase
  end

  // FSM outputs: eligibility mask and the timeout pulse; nobody is eligible in the release cycle.
  always_comb begin
    w_mask         = '1;
    o_lock_timeout = 1'b0;
    case (r_state)
      LA_ARB: begin
        w_mask = '1;
      end
      LA_LOCKED: begin
        w_mask         = w_timeout ? '0 : (NUM_REQ'(1) << r_owner);
        o_lock_timeout = w_timeout;
      end
      default: begin
        w_mask = '1;
      end
    endcase
  end

  // Round-robin pointer, lock owner and idle-while-locked counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr      <= '0;
      r_owner    <= '0;
      r_lock_cnt <= '0;
    end else if (r_state == LA_ARB) begin
      r_lock_cnt <= '0;
      if (w_accept) begin
        r_ptr   <= w_grant_ptr_nxt;
        r_owner <= w_grant_id;
      end
    end else begin
      if (w_timeout) begin
        r_ptr      <= w_owner_ptr_nxt;
        r_lock_cnt <= '0;
      end else if (w_accept) begin
        r_lock_cnt <= '0;
        if (!w_sel_lock) begin
          r_ptr <= w_owner_ptr_nxt;
        end
      end else begin
        r_lock_cnt <= r_lock_cnt + CNTW'(1);
      end
    end
  end

  // Response register: load on accept (even while draining), clear valid on a drain with no accept.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp       <= '0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_id    <= w_grant_id;
      r_rsp       <= w_rsp;
    end else if (i_rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign o_rsp_valid   = r_rsp_valid;
  assign o_rsp_id      = r_rsp_id;
  assign o_rsp_result  = r_rsp.result;
  assign o_rsp_zero    = r_rsp.zero;
  assign o_rsp_neg     = r_rsp.neg;
  assign o_rsp_parity  = r_rsp.parity;
  assign o_rsp_wb      = r_rsp.wb;
  assign o_rsp_illegal = r_rsp.illegal;

endmodule

// File: tb/tb_alu_logic_arbiter.sv
// Directed bench for alu_logic_arbiter with a response scoreboard.
module tb_alu_logic_arbiter;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [11:0] req_ctrl;
  logic [3:0]  req_lock;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_result;
  logic        rsp_zero, rsp_neg, rsp_parity, rsp_wb, rsp_illegal;
  logic        lock_timeout;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [1:0]  id;
    logic [20:0] rsp;   // {result, zero, neg, parity, wb, illegal}
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  alu_logic_arbiter #(.NUM_REQ(4), .LOCK_MAX(8)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_a        (req_a),
    .i_req_b        (req_b),
    .i_req_ctrl     (req_ctrl),
    .i_req_lock     (req_lock),
    .o_rsp_valid    (rsp_valid),
    .i_rsp_ready    (rsp_ready),
    .o_rsp_id       (rsp_id),
    .o_rsp_result   (rsp_result),
    .o_rsp_zero     (rsp_zero),
    .o_rsp_neg      (rsp_neg),
    .o_rsp_parity   (rsp_parity),
    .o_rsp_wb       (rsp_wb),
    .o_rsp_illegal  (rsp_illegal),
    .o_lock_timeout (lock_timeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of the logic unit plus flags.
  function automatic logic [20:0] model(input logic [2:0] c, input logic [15:0] a,
                                        input logic [15:0] b);
    logic [15:0] r;
    logic        legal;
    r     = 16'h0;
    legal = 1'b1;
    case (c)
      LOGIC_AND:  r = a & b;
      LOGIC_OR:   r = a | b;
      LOGIC_XOR:  r = a ^ b;
      LOGIC_NOT:  r = ~a;
      LOGIC_TEST: r = a & b;
      default:    legal = 1'b0;
    endcase
    return {r, (r == 16'h0), r[15], ^r, (legal && (c != LOGIC_TEST)), !legal};
  endfunction

  task automatic set_req(input int k, input logic [2:0] c, input logic [15:0] a,
                         input logic [15:0] b, input logic lk);
    req_valid[k]        = 1'b1;
    req_ctrl[k*3 +: 3]  = c;
    req_a[k*16 +: 16]   = a;
    req_b[k*16 +: 16]   = b;
    req_lock[k]         = lk;
  endtask

  task automatic push_exp(input int k, input logic [20:0] r);
    exp_t e;
    e.id  = 2'(k);
    e.rsp = r;
    sb_q.push_back(e);
  endtask

  task automatic expect_req(input int k);
    push_exp(k, model(req_ctrl[k*3 +: 3], req_a[k*16 +: 16], req_b[k*16 +: 16]));
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Scoreboard: every completed response handshake pops and compares one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      n_cmp++;
      assert (sb_q.size() != 0) else begin
        n_err++;
        $error("FAIL sb_unexpected: observed id %0d result %h expected no response", rsp_id, rsp_result);
      end
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("sb_id", 32'(rsp_id), 32'(e.id));
        check("sb_rsp", 32'({rsp_result, rsp_zero, rsp_neg, rsp_parity, rsp_wb, rsp_illegal}),
              32'(e.rsp));
      end
    end
  end

  initial begin
    // Reset, with every requester asserting valid
    rst = 1'b1; req_valid = 4'hF; req_lock = '0; req_a = '0; req_b = '0; req_ctrl = '0;
    rsp_ready = 1'b1;
    next_cyc(); next_cyc();
    mid();
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_outputs", 32'({rsp_id, rsp_result, rsp_zero, rsp_neg, rsp_parity, rsp_wb,
                              rsp_illegal, lock_timeout}), 32'h0);

    // Round robin: all four valid, ptr starts at 0
    next_cyc();
    rst = 1'b0; req_valid = '0;
    set_req(0, LOGIC_AND, 16'h1234, 16'h00FF, 1'b0);
    set_req(1, LOGIC_OR,  16'h8000, 16'h0001, 1'b0);
    set_req(2, LOGIC_XOR, 16'hFFFF, 16'h0F0F, 1'b0);
    set_req(3, LOGIC_NOT, 16'h00FF, 16'h0000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      mid();
      check($sformatf("rr_grant%0d", i), 32'(req_ready), (32'd1 << (i % 4)));
      if (i > 0) check($sformatf("rr_nobubble%0d", i), 32'(rsp_valid), 32'h1);
      expect_req(i % 4);
      next_cyc();
    end
    req_valid = '0;
    mid();
    check("rr_last_rsp_valid", 32'(rsp_valid), 32'h1);
    next_cyc();
    mid();
    check("rr_idle_rsp_valid", 32'(rsp_valid), 32'h0);

    // Single op from r1
    next_cyc();
    set_req(1, LOGIC_AND, 16'hF0F0, 16'hFF00, 1'b0);
    mid();
    check("single_ready", 32'(req_ready), 32'h2);
    push_exp(1, {16'hF000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
    next_cyc();
    req_valid = '0;
    mid();
    check("single_rsp_valid", 32'(rsp_valid), 32'h1);

    // Backpressure with r2 XOR pending, r0 waiting behind it
    next_cyc();
    set_req(2, LOGIC_XOR, 16'h1234, 16'h1234, 1'b0);
    mid();
    check("bp_accept", 32'(req_ready), 32'h4);
    push_exp(2, {16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
    next_cyc();
    req_valid = '0;
    rsp_ready = 1'b0;
    set_req(0, LOGIC_OR, 16'h0F00, 16'h00F0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      mid();
      check($sformatf("bp_hold_valid%0d", i), 32'(rsp_valid), 32'h1);
      check($sformatf("bp_hold_rsp%0d", i), 32'({rsp_id, rsp_result, rsp_zero}),
            32'({2'd2, 16'h0000, 1'b1}));
      check($sformatf("bp_ready%0d", i), 32'(req_ready), 32'h0);
      next_cyc();
    end
    rsp_ready = 1'b1;
    mid();
    check("bp_drain_accept", 32'(req_ready), 32'h1);
    expect_req(0);
    next_cyc();
    req_valid = '0;
    mid();
    check("bp_next_rsp", 32'({rsp_valid, rsp_id}), 32'({1'b1, 2'd0}));

    // Synchronous reset while a response is stalled
    next_cyc();
    set_req(1, LOGIC_AND, 16'hFFFF, 16'h0001, 1'b0);
    rsp_ready = 1'b0;
    mid();
    check("rstp_accept", 32'(req_ready), 32'h2);
    next_cyc();
    rst = 1'b1;
    req_valid = '0;
    set_req(0, LOGIC_OR, 16'h1111, 16'h2222, 1'b0);
    mid();
    check("rstp_pending", 32'(rsp_valid), 32'h1);
    check("rstp_no_handshake", 32'(req_ready), 32'h0);
    next_cyc();
    rst = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    mid();
    check("rstp_dropped", 32'({rsp_valid, rsp_id, rsp_result, lock_timeout}), 32'h0);

    // Lock: r0 issues three ops (lock 1,1,0) while r1..r3 compete
    next_cyc();
    set_req(0, LOGIC_AND, 16'h00F3, 16'h0F0F, 1'b1);
    set_req(1, LOGIC_XOR, 16'h5A5A, 16'hFFFF, 1'b0);
    set_req(2, LOGIC_OR,  16'h0001, 16'h0002, 1'b0);
    set_req(3, LOGIC_NOT, 16'h7FFF, 16'h0000, 1'b0);
    mid();
    check("lock_g0", 32'(req_ready), 32'h1);
    expect_req(0);
    next_cyc();
    set_req(0, LOGIC_OR, 16'h8000, 16'h0100, 1'b1);
    mid();
    check("lock_g1", 32'(req_ready), 32'h1);
    expect_req(0);
    next_cyc();
    set_req(0, LOGIC_NOT, 16'hFFFF, 16'h0000, 1'b0);
    mid();
    check("lock_g2", 32'(req_ready), 32'h1);
    expect_req(0);
    next_cyc();
    req_valid[0] = 1'b0;
    mid();
    check("lock_release_r1", 32'(req_ready), 32'h2);
    expect_req(1);
    next_cyc();
    req_valid = '0;
    mid();
    next_cyc();

    // Timeout: r3 locks then goes idle while r0 waits
    set_req(3, LOGIC_XOR, 16'hAAAA, 16'h5555, 1'b1);
    mid();
    check("to_lock_r3", 32'(req_ready), 32'h8);
    expect_req(3);
    next_cyc();
    req_valid = '0;
    set_req(0, LOGIC_NOT, 16'h0F0F, 16'h0000, 1'b0);
    for (int i = 0; i < 8; i++) begin
      mid();
      check($sformatf("to_idle_ready%0d", i), 32'(req_ready), 32'h0);
      check($sformatf("to_idle_pulse%0d", i), 32'(lock_timeout), 32'h0);
      next_cyc();
    end
    mid();
    check("to_pulse", 32'(lock_timeout), 32'h1);
    check("to_pulse_no_accept", 32'(req_ready), 32'h0);
    next_cyc();
    mid();
    check("to_after_grant_r0", 32'(req_ready), 32'h1);
    check("to_after_pulse", 32'(lock_timeout), 32'h0);
    expect_req(0);
    next_cyc();
    req_valid = '0;
    mid();

    // Edge cases: TEST op and illegal op codes
    next_cyc();
    set_req(2, LOGIC_TEST, 16'h00FF, 16'hFF00, 1'b0);
    mid();
    check("test_accept", 32'(req_ready), 32'h4);
    push_exp(2, {16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    next_cyc();
    req_valid = '0;
    set_req(1, 3'd7, 16'hFFFF, 16'hFFFF, 1'b0);
    mid();
    check("illegal_accept", 32'(req_ready), 32'h2);
    push_exp(1, {16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
    next_cyc();
    req_valid = '0;
    set_req(3, 3'd5, 16'h1234, 16'h4321, 1'b0);
    mid();
    check("illegal5_accept", 32'(req_ready), 32'h8);
    expect_req(3);
    next_cyc();
    req_valid = '0;
    mid();
    next_cyc();
    mid();

    check("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
